rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Write-back controller in front of the register file's single write port.
- Arbitrates NUM_REQ write-back requesters (e.g. EXU, LSU) onto the port using valid/ready handshakes.
- Registers the winning write for one cycle and keeps a busy scoreboard of destination registers that have an outstanding write.
- The decode stage reads busy_vec to stall on RAW hazards.

Parameters:
- ADDR_WIDTH, 5, register address width; 2**ADDR_WIDTH registers.
- DATA_WIDTH, 32, register data width.
- NUM_REQ, 2, number of write-back requesters (2..4).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester write request.
- req_ready  output  NUM_REQ  per-requester grant; request accepted when valid&ready.
- req_waddr  input  NUM_REQ*ADDR_WIDTH  packed destination addresses, requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  input  NUM_REQ*DATA_WIDTH  packed write data, same packing.
- rf_wen  output  1  register file write enable.
- rf_waddr  output  ADDR_WIDTH  register file write address.
- rf_wdata  output  DATA_WIDTH  register file write data.
- alloc_valid  input  1  issue stage marks alloc_addr as pending write.
- alloc_addr  input  ADDR_WIDTH  register to mark busy.
- flush  input  1  clear all busy bits (pipeline flush).
- busy_vec  output  2**ADDR_WIDTH  bit r = 1: register r has an outstanding write.

Behaviour:
- Reset (async, rst_n=0):
  - rf_wen=0, rf_waddr=0, rf_wdata=0.
  - busy_vec=0.
  - Round-robin pointer=0.
  - Takes effect immediately, mid-operation included; an in-flight write is dropped.
- Arbitration (combinational):
  - At most one req_ready bit high per cycle.
  - req_ready[i]=1 only if req_valid[i]=1 and i is the highest-priority valid requester.
  - Priority order starts at the pointer and wraps modulo NUM_REQ.
  - The port never back-pressures, so a request is granted every cycle at least one is valid.
- Pointer update: after a grant to i, pointer <= (i+1) mod NUM_REQ. No grant: pointer unchanged.
- Requester rule: valid, waddr and wdata are held stable until ready. The arbiter does not depend on this.
- Output stage, latency 1 cycle:
  - A request accepted in cycle t drives rf_wen=1 with its rf_waddr/rf_wdata in cycle t+1, for exactly one cycle.
  - No acceptance in t: rf_wen=0 in t+1; rf_waddr/rf_wdata hold their previous values.
- x0 writes:
  - Request with waddr=0 is still granted (consumed) and advances the pointer.
  - rf_wen stays 0 in t+1.
- Scoreboard:
  - Set: alloc_valid=1 with alloc_addr!=0 sets busy[alloc_addr] at the next edge.
  - Clear: busy[rf_waddr] clears at the edge ending a cycle with rf_wen=1.
  - Set and clear on the same register in the same cycle: set wins, bit stays 1 (new producer allocated).
  - flush=1 clears every bit at the next edge, except alloc in the same cycle: the allocated bit is set.
  - busy[0] is constant 0.
  - Writes already in the output stage still commit after a flush.
- No other state. No stall or timeout logic.

Optional Feature:
- Macro: RF_WB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins (requester 0 highest); the pointer register is not instantiated.
- Undefined: round-robin as in Behaviour.
- Ports, latency and scoreboard are identical in both builds.

Test Plan:
- Reset: assert rst_n=0 mid-stream while rf_wen=1 -> rf_wen=0, busy_vec=0 immediately. After release, first contended grant goes to requester 0.
- Single write:
  - Cycle 0: alloc x5 -> busy[5]=1.
  - Cycle 2: req0 valid, waddr=5, wdata=0xDEADBEEF -> req_ready[0]=1 in cycle 2.
  - Cycle 3: rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
  - Cycle 4: busy[5]=0.
- Contention: req0 (x1, 0x11) and req1 (x2, 0x22) valid continuously from reset -> grants alternate 0,1,0,1; rf_waddr sequence 1,2,1,2; with RF_WB_FIXED_PRIO_EN, req0 granted every cycle.
- x0: req1 waddr=0, wdata=0x1234 -> req_ready[1]=1; next cycle rf_wen=0; busy[0]=0 throughout.
- Same-cycle set/clear:
  - busy[7]=1; write to x7 committing in cycle t (rf_wen=1).
  - alloc_valid=1, alloc_addr=7 in cycle t -> busy[7]=1 after the edge.
- Flush:
  - busy[3], busy[9] set; flush=1 with alloc x4 in the same cycle -> busy_vec = only bit 4.
  - In-flight write to x3 still produces rf_wen=1.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file write-back arbiter with busy scoreboard
// Define RF_WB_FIXED_PRIO_EN for fixed priority (requester 0 highest) instead of round-robin.
module rf_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_waddr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic                          rf_wen,
    output logic [ADDR_WIDTH-1:0]         rf_waddr,
    output logic [DATA_WIDTH-1:0]         rf_wdata,
    input  logic                          alloc_valid,
    input  logic [ADDR_WIDTH-1:0]         alloc_addr,
    input  logic                          flush,
    output logic [(1<<ADDR_WIDTH)-1:0]    busy_vec
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;
    localparam int PTR_W    = (NUM_REQ > 2) ? 2 : 1;

    logic [NUM_REQ-1:0]    w_req_ready;
    logic                  w_any;
    int                    w_sel_idx;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_commit;

    logic                  r_wen;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [NUM_REGS-1:0]   r_busy;
    logic [NUM_REGS-1:0]   w_busy_nxt;

`ifndef RF_WB_FIXED_PRIO_EN
    logic [PTR_W-1:0]      r_ptr;
`endif

    // Scan requesters starting at the priority base; the first valid one wins.
    always_comb begin : p_arb
        int base;
        int idx;
        w_req_ready = '0;
        w_any       = 1'b0;
        w_sel_idx   = 0;
        w_sel_addr  = '0;
        w_sel_data  = '0;
        idx         = 0;
`ifdef RF_WB_FIXED_PRIO_EN
        base        = 0;
`else
        base        = int'(r_ptr);
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = base + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!w_any && req_valid[idx]) begin
                w_any            = 1'b1;
                w_req_ready[idx] = 1'b1;
                w_sel_idx        = idx;
                w_sel_addr       = req_waddr[idx*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_data       = req_wdata[idx*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // x0 requests are consumed but never reach the register file.
    assign w_commit = w_any && (w_sel_addr != '0);

`ifndef RF_WB_FIXED_PRIO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_any) begin
            if (w_sel_idx == NUM_REQ - 1) r_ptr <= '0;
            else                          r_ptr <= PTR_W'(w_sel_idx + 1);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_wen <= w_commit;
            if (w_commit) begin
                r_waddr <= w_sel_addr;
                r_wdata <= w_sel_data;
            end
        end
    end

    // A fresh allocation overrides both a retiring write and a flush.
    always_comb begin
        w_busy_nxt = r_busy;
        if (flush)      w_busy_nxt = '0;
        else if (r_wen) w_busy_nxt[r_waddr] = 1'b0;
        if (alloc_valid && (alloc_addr != '0)) w_busy_nxt[alloc_addr] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_busy <= '0;
        else        r_busy <= w_busy_nxt;
    end

    assign req_ready = w_req_ready;
    assign rf_wen    = r_wen;
    assign rf_waddr  = r_waddr;
    assign rf_wdata  = r_wdata;
    assign busy_vec  = r_busy;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - directed self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [9:0]  req_waddr;
    logic [63:0] req_wdata;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        alloc_valid;
    logic [4:0]  alloc_addr;
    logic        flush;
    logic [31:0] busy_vec;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_REQ(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_waddr(req_waddr), .req_wdata(req_wdata),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
        .flush(flush), .busy_vec(busy_vec)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_rdy [4];
        logic [4:0] exp_adr [4];
`ifdef RF_WB_FIXED_PRIO_EN
        exp_rdy = '{2'b01, 2'b01, 2'b01, 2'b01};
        exp_adr = '{5'd1, 5'd1, 5'd1, 5'd1};
`else
        exp_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_adr = '{5'd1, 5'd2, 5'd1, 5'd2};
`endif
        rst_n = 1'b0; req_valid = '0; req_waddr = '0; req_wdata = '0;
        alloc_valid = 1'b0; alloc_addr = '0; flush = 1'b0;
        repeat (3) tick();
        chk("rst_wen", rf_wen, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_busy", busy_vec, 0);

        // Contention straight out of reset
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 2'b11; req_waddr = {5'd2, 5'd1}; req_wdata = {32'h22, 32'h11};
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("cont_ready%0d", i), req_ready, exp_rdy[i]);
            tick();
            chk($sformatf("cont_wen%0d", i), rf_wen, 1);
            chk($sformatf("cont_waddr%0d", i), rf_waddr, exp_adr[i]);
            chk($sformatf("cont_wdata%0d", i), rf_wdata, (exp_adr[i] == 5'd1) ? 32'h11 : 32'h22);
        end
        req_valid = 2'b00;
        tick();
        chk("idle_wen", rf_wen, 0);
        chk("idle_waddr_hold", rf_waddr, exp_adr[3]);

        // Single write to x5 with scoreboard set/clear
        alloc_valid = 1'b1; alloc_addr = 5'd5;
        tick();
        alloc_valid = 1'b0;
        chk("sw_busy_set", busy_vec, 32'h20);
        tick();
        req_valid = 2'b01; req_waddr = {5'd0, 5'd5}; req_wdata = {32'h0, 32'hDEADBEEF};
        #1;
        chk("sw_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        chk("sw_wen", rf_wen, 1);
        chk("sw_waddr", rf_waddr, 5);
        chk("sw_wdata", rf_wdata, 32'hDEADBEEF);
        chk("sw_busy_still", busy_vec, 32'h20);
        tick();
        chk("sw_busy_clr", busy_vec, 0);
        chk("sw_wen_drop", rf_wen, 0);

        // x0 write: consumed but not committed
        req_valid = 2'b10; req_waddr = {5'd0, 5'd0}; req_wdata = {32'h1234, 32'h0};
        #1;
        chk("x0_ready", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        chk("x0_wen", rf_wen, 0);
        chk("x0_waddr_hold", rf_waddr, 5);
        chk("x0_busy0", busy_vec[0], 0);

        // Same-cycle set and clear on x7
        alloc_valid = 1'b1; alloc_addr = 5'd7;
        tick();
        alloc_valid = 1'b0;
        chk("sc_busy_set", busy_vec, 32'h80);
        req_valid = 2'b01; req_waddr = {5'd0, 5'd7}; req_wdata = {32'h0, 32'h77};
        #1;
        chk("sc_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        chk("sc_wen", rf_wen, 1);
        chk("sc_waddr", rf_waddr, 7);
        alloc_valid = 1'b1; alloc_addr = 5'd7;
        tick();
        alloc_valid = 1'b0;
        chk("sc_busy_kept", busy_vec, 32'h80);

        // Flush with concurrent alloc and an accepted write to x3
        alloc_valid = 1'b1; alloc_addr = 5'd3;
        tick();
        alloc_addr = 5'd9;
        tick();
        alloc_valid = 1'b0;
        chk("fl_busy_pre", busy_vec, 32'h288);
        req_valid = 2'b01; req_waddr = {5'd0, 5'd3}; req_wdata = {32'h0, 32'h33};
        flush = 1'b1; alloc_valid = 1'b1; alloc_addr = 5'd4;
        #1;
        chk("fl_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00; flush = 1'b0; alloc_valid = 1'b0;
        chk("fl_busy", busy_vec, 32'h10);
        chk("fl_wen", rf_wen, 1);
        chk("fl_waddr", rf_waddr, 3);
        chk("fl_wdata", rf_wdata, 32'h33);
        tick();
        chk("fl_busy_after", busy_vec, 32'h10);

        // Mid-stream async reset; requester 0 granted, so pointer sits at 1 beforehand
        req_valid = 2'b01; req_waddr = {5'd2, 5'd1}; req_wdata = {32'h22, 32'h11};
        alloc_valid = 1'b1; alloc_addr = 5'd6;
        tick();
        req_valid = 2'b00; alloc_valid = 1'b0;
        chk("mr_wen_pre", rf_wen, 1);
        chk("mr_busy_pre", busy_vec, 32'h50);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_wen", rf_wen, 0);
        chk("mr_busy", busy_vec, 0);
        chk("mr_waddr", rf_waddr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 2'b11;
        #1;
        chk("mr_first_grant", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        chk("mr_first_waddr", rf_waddr, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
